i2s_sequencer: RTL

I2S_SEQUENCER -- requirements
Module: i2s_sequencer

---
 rtl/i2s_pkg.sv | 25 ++
 rtl/i2s_sample_fifo.sv | 45 ++++
 rtl/i2s_sequencer.sv | 109 ++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// i2s_pkg: rate codes, divider table, FSM state encoding and frame geometry shared by the I2S sequencer.
package i2s_pkg;

    localparam logic [1:0] RATE_48K  = 2'd0;
    localparam logic [1:0] RATE_96K  = 2'd1;
    localparam logic [1:0] RATE_192K = 2'd2;

    localparam logic [3:0] DIV_N [3] = '{4'd8, 4'd4, 4'd2};

    localparam int FRAME_BITS = 64;
    localparam int FIFO_DEPTH = 2;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;

    // Reload value for the half-period counter; code 3 runs at the 192k ratio.
    function automatic logic [2:0] half_reload(input logic [1:0] r);
        logic [3:0] n;
        n = (r == RATE_48K) ? DIV_N[0] : (r == RATE_96K) ? DIV_N[1] : DIV_N[2];
        return 3'((n >> 1) - 4'd1);
    endfunction

endpackage

// File: rtl/i2s_sample_fifo.sv
// i2s_sample_fifo: two-entry valid/ready buffer for DDC sample pairs.
module i2s_sample_fifo
    import i2s_pkg::*;
#(
    parameter int W = 48
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_pop
);

    logic [W-1:0] mem [FIFO_DEPTH];
    logic         wp, rp, en;
    logic [1:0]   cnt;
    logic         push, pop;

    // en keeps ready low until the first clock after reset release.
    assign in_ready  = en && cnt != 2'(FIFO_DEPTH);
    assign out_valid = cnt != 2'd0;
    assign out_data  = mem[rp];
    assign push      = in_valid && in_ready;
    assign pop       = out_pop && out_valid;

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            wp  <= 1'b0;
            rp  <= 1'b0;
            cnt <= 2'd0;
            en  <= 1'b0;
        end else begin
            en  <= 1'b1;
            wp  <= wp ^ push;
            rp  <= rp ^ pop;
            cnt <= cnt + 2'(push) - 2'(pop);
        end

    always_ff @(posedge clock)
        if (push) mem[wp] <= in_data;

endmodule

// File: rtl/i2s_sequencer.sv
// i2s_sequencer: I2S bit/word clock generator with frame sequencing from a DDC sample FIFO.
// Define I2S_UNDERRUN_CNT_EN to build the saturating underrun frame counter.
module i2s_sequencer
    import i2s_pkg::*;
#(
    parameter int DATA_W = 24
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        s_rate,
    input  logic              enable,
    input  logic [DATA_W-1:0] rx_real,
    input  logic [DATA_W-1:0] rx_imag,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              bclk,
    output logic              lrclk,
    output logic              bclk_fall,
    output logic [5:0]        bit_cnt,
    output logic              frame_start,
    output logic [63:0]       frame_data,
    output logic              underrun,
    output logic [15:0]       underrun_cnt
);

    state_t              state, nxt;
    logic [2:0]          half, reload;
    logic                fifo_valid, pop, fall, wrap, entry, frame_ld;
    logic [2*DATA_W-1:0] head;
    logic [63:0]         head_word;
    logic [5:0]          bit_nxt;

    i2s_sample_fifo #(.W(2*DATA_W)) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .in_data  ({rx_real, rx_imag}),
        .in_valid (rx_valid),
        .in_ready (rx_ready),
        .out_data (head),
        .out_valid(fifo_valid),
        .out_pop  (pop)
    );

    assign fall      = state != ST_IDLE && bclk && half == 3'd0;
    assign wrap      = fall && bit_cnt == 6'(FRAME_BITS - 1);
    assign entry     = state == ST_IDLE && enable;
    assign nxt       = enable ? ST_RUN :
                       (state == ST_IDLE || (state == ST_DRAIN && wrap)) ? ST_IDLE : ST_DRAIN;
    assign frame_ld  = wrap && nxt != ST_IDLE;
    assign pop       = fifo_valid && (entry || frame_ld);
    assign bit_nxt   = bit_cnt + 6'd1;
    assign head_word = {32'(head[2*DATA_W-1 -: DATA_W]) << (32 - DATA_W),
                        32'(head[DATA_W-1:0]) << (32 - DATA_W)};

    // The falling edge that ends bit 63 reloads the divider at the newly latched rate.
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            state       <= ST_IDLE;
            half        <= 3'd0;
            reload      <= 3'd0;
            bclk        <= 1'b0;
            lrclk       <= 1'b0;
            bit_cnt     <= 6'd0;
            bclk_fall   <= 1'b0;
            frame_start <= 1'b0;
            frame_data  <= '0;
            underrun    <= 1'b0;
        end else begin
            state       <= nxt;
            bclk_fall   <= 1'b0;
            frame_start <= 1'b0;
            if (nxt == ST_IDLE) begin
                half    <= 3'd0;
                bclk    <= 1'b0;
                lrclk   <= 1'b0;
                bit_cnt <= 6'd0;
            end else if (entry) begin
                reload     <= half_reload(s_rate);
                half       <= half_reload(s_rate);
                bclk       <= 1'b1;
                frame_data <= fifo_valid ? head_word : '0;
            end else if (half != 3'd0) begin
                half <= half - 3'd1;
            end else begin
                bclk <= !bclk;
                half <= wrap ? half_reload(s_rate) : reload;
                if (bclk) begin
                    bclk_fall <= 1'b1;
                    bit_cnt   <= bit_nxt;
                    lrclk     <= bit_nxt[5];
                end
                if (wrap) begin
                    frame_start <= 1'b1;
                    reload      <= half_reload(s_rate);
                    frame_data  <= fifo_valid ? head_word : frame_data;
                    underrun    <= underrun | !fifo_valid;
                end
            end
        end

`ifdef I2S_UNDERRUN_CNT_EN
    always_ff @(posedge clock or negedge reset)
        if (!reset) underrun_cnt <= 16'd0;
        else if (frame_ld && !fifo_valid && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
`else
    assign underrun_cnt = 16'd0;
`endif

endmodule
